// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one single-port memory between fetch and data ports
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int               CNT_W      = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic             C_OWNER_IF = 1'b0;
  localparam logic             C_OWNER_D  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner;
  logic             r_we;
  logic             r_last_grant;

  logic w_any_req;
  logic w_grant_d;
  logic w_grant_store;

  // Data wins only when alone or when fetch was the previous winner.
  assign w_any_req     = if_req | d_req;
  assign w_grant_d     = d_req & (~if_req | (r_last_grant == C_OWNER_IF));
  assign w_grant_store = w_grant_d & d_we;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_owner      <= C_OWNER_IF;
      r_we         <= 1'b0;
      r_last_grant <= C_OWNER_D;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_ISSUE;
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            r_we         <= w_grant_store;
            // The mem_* registers double as the latched request for ISSUE.
            mem_en       <= 1'b1;
            mem_we       <= w_grant_store;
            mem_addr     <= w_grant_d ? d_addr : if_addr;
            mem_wdata    <= w_grant_store ? d_wdata : '0;
          end
        end
        S_ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (r_we) begin
            r_state <= S_DONE;
            d_ready <= 1'b1;
          end else begin
            r_cnt   <= C_CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            if (r_owner == C_OWNER_D) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
